// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply engine: FSM states, operand
// bank selects and the accumulator-to-element formatting rule.
package matmul_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, MAC, WRITE, DONE} state_t;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  // Width of the container used by fmt_result; accumulators are extended to it.
  localparam int FMT_W = 64;

  // Map an accumulator (already extended to FMT_W) onto a data_w-bit element.
  // The caller keeps the low data_w bits of the returned value.
  function automatic logic [FMT_W-1:0] fmt_result(
    input logic [FMT_W-1:0] acc,
    input int               data_w,
    input logic             is_signed,
    input logic             saturate
  );
    logic [FMT_W-1:0] umax;
    logic [FMT_W-1:0] smax;
    logic [FMT_W-1:0] smin;
    umax = (64'd1 << data_w) - 64'd1;
    smax = (64'd1 << (data_w - 1)) - 64'd1;
    smin = ~smax;
    if (!saturate) begin
      return acc;
    end
    if (!is_signed) begin
      return (acc > umax) ? umax : acc;
    end
    if ($signed(acc) > $signed(smax)) begin
      return smax;
    end
    if ($signed(acc) < $signed(smin)) begin
      return smin;
    end
    return acc;
  endfunction

endpackage

// File: rtl/matmul_engine_mac_lane.sv
// One multiply-accumulate lane: builds one C element as the dot product of
// a row of A and a column of B, one term per enabled cycle.
module mac_lane
  import matmul_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 2 * DATA_W + 2,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o
);

  logic                  sign_a;
  logic                  sign_b;
  logic                  sign_p;
  logic                  sign_acc;
  logic [2*DATA_W-1:0]   a_ext;
  logic [2*DATA_W-1:0]   b_ext;
  logic [2*DATA_W-1:0]   prod;
  logic [ACC_W-1:0]      prod_ext;
  logic [ACC_W-1:0]      acc_q;
  logic [ACC_W-1:0]      acc_d;

  // Extending both operands to the product width makes the low half of an
  // ordinary multiply the correct signed or unsigned product.
  assign sign_a   = (SIGNED != 0) & a_i[DATA_W-1];
  assign sign_b   = (SIGNED != 0) & b_i[DATA_W-1];
  assign a_ext    = {{DATA_W{sign_a}}, a_i};
  assign b_ext    = {{DATA_W{sign_b}}, b_i};
  assign prod     = a_ext * b_ext;
  assign sign_p   = (SIGNED != 0) & prod[2*DATA_W-1];
  assign prod_ext = {{(ACC_W - 2*DATA_W){sign_p}}, prod};
  assign sign_acc = (SIGNED != 0) & acc_q[ACC_W-1];

  // Next accumulator: a clear together with enable starts a fresh sum with this term.
  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      acc_d = (clear_i ? '0 : acc_q) + prod_ext;
    end else if (clear_i) begin
      acc_d = '0;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign result_o = DATA_W'(fmt_result({{(FMT_W - ACC_W){sign_acc}}, acc_q},
                                       DATA_W, SIGNED != 0, SATURATE != 0));

endmodule

// File: rtl/matmul_engine.sv
// N x N integer matrix multiply C = A x B with LANES parallel MAC lanes.
// Lane l works on row p*LANES+l in pass p; each column j takes N MAC cycles
// followed by one WRITE cycle that stores every active lane's result.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int N        = 3,
  parameter int LANES    = 3,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 2 * DATA_W + $clog2(N),
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1,
  parameter int ADDR_W   = $clog2(N * N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              load_sel,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              load_err,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int                PASSES = (N + LANES - 1) / LANES;
  localparam int                CNT_W  = $clog2(N + 1);
  localparam logic [CNT_W-1:0]  K_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0]  P_LAST = CNT_W'(PASSES - 1);
  localparam logic [ADDR_W:0]   NUM_EL = (ADDR_W + 1)'(N * N);

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic              load_err_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [CNT_W-1:0]  p_q;
  logic [CNT_W-1:0]  j_q;
  logic [CNT_W-1:0]  k_q;

  logic [DATA_W-1:0] a_mem [N*N];
  logic [DATA_W-1:0] b_mem [N*N];
  logic [DATA_W-1:0] c_mem [N*N];

  logic                          load_ok;
  logic                          rd_ok;
  logic                          lane_clear;
  logic [ADDR_W-1:0]             b_idx;
  logic [LANES-1:0]              lane_act;
  logic [LANES-1:0][ADDR_W-1:0]  lane_aidx;
  logic [LANES-1:0][ADDR_W-1:0]  lane_cidx;
  logic [LANES-1:0][DATA_W-1:0]  lane_res;

  assign load_ok    = load_en && !busy_q && ({1'b0, load_addr} < NUM_EL);
  assign rd_ok      = {1'b0, rd_addr} < NUM_EL;
  // The first MAC cycle of every column restarts the sums, so no CLEAR is
  // needed between columns.
  assign lane_clear = (state_q == CLEAR) || ((state_q == MAC) && (k_q == '0));
  assign b_idx      = ADDR_W'(int'(k_q) * N + int'(j_q));

  // Row ownership per lane; lanes beyond the last row are masked off so
  // their out-of-range addresses are never used.
  always_comb begin
    lane_act  = '0;
    lane_aidx = '0;
    lane_cidx = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_act[l] = (int'(p_q) * LANES + l) < N;
      if (lane_act[l]) begin
        lane_aidx[l] = ADDR_W'((int'(p_q) * LANES + l) * N + int'(k_q));
        lane_cidx[l] = ADDR_W'((int'(p_q) * LANES + l) * N + int'(j_q));
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    mac_lane #(
      .DATA_W  (DATA_W),
      .ACC_W   (ACC_W),
      .SIGNED  (SIGNED),
      .SATURATE(SATURATE)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clear_i (lane_clear),
      .en_i    ((state_q == MAC) && lane_act[gi]),
      .a_i     (a_mem[lane_aidx[gi]]),
      .b_i     (b_mem[b_idx]),
      .result_o(lane_res[gi])
    );
  end

  // Sequencer: pass/column/term counters with registered busy and done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          p_q     <= '0;
          j_q     <= '0;
          k_q     <= '0;
          state_q <= MAC;
        end
        MAC: begin
          if (k_q == K_LAST) begin
            state_q <= WRITE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        WRITE: begin
          k_q <= '0;
          if (j_q != K_LAST) begin
            j_q     <= j_q + 1'b1;
            state_q <= MAC;
          end else if (p_q != P_LAST) begin
            p_q     <= p_q + 1'b1;
            j_q     <= '0;
            state_q <= MAC;
          end else begin
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operand banks: written only by accepted loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N * N; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
      end
    end else if (load_ok) begin
      case (load_sel)
        BANK_A: a_mem[load_addr] <= load_data;
        BANK_B: b_mem[load_addr] <= load_data;
      endcase
    end
  end

  // Result bank with registered read port; readable at any time.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N * N; i++) begin
        c_mem[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (state_q == WRITE) begin
        for (int l = 0; l < LANES; l++) begin
          if (lane_act[l]) begin
            c_mem[lane_cidx[l]] <= lane_res[l];
          end
        end
      end
      rd_data_q <= rd_ok ? c_mem[rd_addr] : '0;
    end
  end

  // Rejected-load flag, one cycle after the offending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_en && !load_ok;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign load_err = load_err_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Bench for matmul_engine: three configurations (defaults; N=3 LANES=1
// wrapping; N=4 LANES=3 signed saturating) checked against a plain
// triple-loop matrix product.
module tb_matmul_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       load_en   [3];
  logic       load_sel  [3];
  logic [3:0] load_addr [3];
  logic [7:0] load_data [3];
  logic       start     [3];
  logic       busy      [3];
  logic       done      [3];
  logic       load_err  [3];
  logic [3:0] rd_addr   [3];
  logic [7:0] rd_data   [3];

  logic [7:0] ma  [3][16];
  logic [7:0] mb  [3][16];
  logic [7:0] got [16];

  int n_checks = 0;
  int n_fail   = 0;

  matmul_engine #(.N(3), .LANES(3), .SIGNED(0), .SATURATE(1)) u_def (
    .clk(clk), .reset(reset), .load_en(load_en[0]), .load_sel(load_sel[0]),
    .load_addr(load_addr[0]), .load_data(load_data[0]), .start(start[0]),
    .busy(busy[0]), .done(done[0]), .load_err(load_err[0]),
    .rd_addr(rd_addr[0]), .rd_data(rd_data[0]));

  matmul_engine #(.N(3), .LANES(1), .SIGNED(0), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .load_en(load_en[1]), .load_sel(load_sel[1]),
    .load_addr(load_addr[1]), .load_data(load_data[1]), .start(start[1]),
    .busy(busy[1]), .done(done[1]), .load_err(load_err[1]),
    .rd_addr(rd_addr[1]), .rd_data(rd_data[1]));

  matmul_engine #(.N(4), .LANES(3), .SIGNED(1), .SATURATE(1)) u_n4 (
    .clk(clk), .reset(reset), .load_en(load_en[2]), .load_sel(load_sel[2]),
    .load_addr(load_addr[2]), .load_data(load_data[2]), .start(start[2]),
    .busy(busy[2]), .done(done[2]), .load_err(load_err[2]),
    .rd_addr(rd_addr[2]), .rd_data(rd_data[2]));

  // ---------------- configuration and reference model ----------------
  function automatic int dim(int d);
    return (d == 2) ? 4 : 3;
  endfunction

  function automatic int lanes_of(int d);
    return (d == 1) ? 1 : 3;
  endfunction

  function automatic int exp_lat(int d);
    int n;
    int passes;
    n = dim(d);
    passes = (n + lanes_of(d) - 1) / lanes_of(d);
    return 2 + passes * n * (n + 1);
  endfunction

  function automatic int val(int d, logic [7:0] x);
    if (d == 2) return int'($signed(x));
    return int'(x);
  endfunction

  function automatic logic [7:0] exp_c(int d, int idx);
    int n;
    int r;
    int c;
    int s;
    n = dim(d);
    r = idx / n;
    c = idx % n;
    s = 0;
    for (int k = 0; k < n; k++) begin
      s += val(d, ma[d][r*n+k]) * val(d, mb[d][k*n+c]);
    end
    if (d == 0) begin
      if (s > 255) s = 255;
    end else if (d == 2) begin
      if (s > 127) s = 127;
      if (s < -128) s = -128;
    end
    return s[7:0];
  endfunction

  function automatic logic [7:0] gen(int mode, int r, int c);
    int t [16];
    t = '{-128, 5, -7, 100, -100, -100, -100, 0, 127, 127, 0, 0, 1, 2, 3, 4};
    case (mode)
      0:       return 8'(r * 3 + c + 1);
      1:       return (r == c) ? 8'd1 : 8'd0;
      2:       return 8'd255;
      3:       return 8'($urandom_range(0, 255));
      4:       return 8'd1;
      default: return 8'(t[r*4+c]);
    endcase
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) begin
        ma[d][i] = 8'd0;
        mb[d][i] = 8'd0;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_elem(int d, logic sel, int addr, logic [7:0] data);
    load_en[d]   = 1'b1;
    load_sel[d]  = sel;
    load_addr[d] = 4'(addr);
    load_data[d] = data;
    tick();
    load_en[d] = 1'b0;
  endtask

  task automatic load_bank(int d, logic sel, int mode);
    int n;
    logic [7:0] v;
    n = dim(d);
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        v = gen(mode, r, c);
        load_elem(d, sel, r * n + c, v);
        if (sel) mb[d][r*n+c] = v;
        else     ma[d][r*n+c] = v;
      end
    end
  endtask

  task automatic run_compute(int d, output int cycles);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    cycles = 0;
    while (done[d] !== 1'b1 && cycles < 1000) begin
      tick();
      cycles++;
    end
  endtask

  task automatic read_all(int d);
    for (int i = 0; i < dim(d) * dim(d); i++) begin
      rd_addr[d] = 4'(i);
      tick();
      got[i] = rd_data[d];
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_clear();
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (busy[d] !== 1'b0 || done[d] !== 1'b0 || load_err[d] !== 1'b0 || rd_data[d] !== 8'd0) begin
        n_fail++;
        $display("FAIL reset dut%0d: busy=%b done=%b load_err=%b rd_data=%0d, required all 0",
                 d, busy[d], done[d], load_err[d], rd_data[d]);
      end
    end
    $display("reset: %0d outputs checked", 3);
  endtask

  task automatic test_product(int d, int mode_a, int mode_b, string tag);
    int cyc;
    load_bank(d, 1'b0, mode_a);
    load_bank(d, 1'b1, mode_b);
    run_compute(d, cyc);
    n_checks++;
    if (cyc != exp_lat(d)) begin
      n_fail++;
      $display("FAIL %s latency dut%0d: got %0d cycles, required %0d", tag, d, cyc, exp_lat(d));
    end
    n_checks++;
    if (busy[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_at_done dut%0d: got %b, required 0", tag, d, busy[d]);
    end
    tick();
    n_checks++;
    if (done[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse dut%0d: got %b one cycle later, required 0", tag, d, done[d]);
    end
    read_all(d);
    for (int i = 0; i < dim(d) * dim(d); i++) begin
      n_checks++;
      if (got[i] !== exp_c(d, i)) begin
        n_fail++;
        $display("FAIL %s C[%0d] dut%0d: got %0d, required %0d", tag, i, d, got[i], exp_c(d, i));
      end
    end
    $display("%s dut%0d: latency %0d, C[0]=%0d", tag, d, cyc, got[0]);
  endtask

  task automatic test_identity();
    test_product(0, 0, 1, "identity");
  endtask

  task automatic test_square();
    test_product(0, 0, 0, "square");
    n_checks++;
    if (got[0] !== 8'd30 || got[4] !== 8'd81) begin
      n_fail++;
      $display("FAIL square_const: got C[0]=%0d C[4]=%0d, required 30 and 81", got[0], got[4]);
    end
  endtask

  task automatic test_saturate();
    test_product(0, 2, 2, "sat255");
    test_product(1, 2, 2, "wrap255");
  endtask

  task automatic test_n4();
    test_product(2, 1, 1, "n4_identity");
    test_product(2, 5, 1, "signed_eye");
    test_product(2, 5, 4, "signed_ones");
  endtask

  task automatic test_random();
    for (int it = 0; it < 2; it++) begin
      for (int d = 0; d < 3; d++) begin
        test_product(d, 3, 3, "random");
      end
    end
  endtask

  task automatic test_midrun();
    int cyc;
    logic [7:0] old_a0;
    load_bank(0, 1'b0, 3);
    load_bank(0, 1'b1, 3);
    old_a0 = ma[0][0];
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    start[0]     = 1'b1;
    load_en[0]   = 1'b1;
    load_sel[0]  = 1'b0;
    load_addr[0] = 4'd0;
    load_data[0] = old_a0 + 8'd1;
    tick();
    start[0]   = 1'b0;
    load_en[0] = 1'b0;
    cyc = 3;
    n_checks++;
    if (load_err[0] !== 1'b1 || busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_load: load_err=%b busy=%b, required 1 and 1", load_err[0], busy[0]);
    end
    while (done[0] !== 1'b1 && cyc < 1000) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != exp_lat(0)) begin
      n_fail++;
      $display("FAIL restart_latency: got %0d cycles, required %0d", cyc, exp_lat(0));
    end
    read_all(0);
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (got[i] !== exp_c(0, i)) begin
        n_fail++;
        $display("FAIL midrun C[%0d]: got %0d, required %0d", i, got[i], exp_c(0, i));
      end
    end
    $display("midrun: latency %0d with ignored start and rejected load", cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    load_en[0]   = 1'b1;
    load_sel[0]  = 1'b0;
    load_addr[0] = 4'd4;
    load_data[0] = 8'd200;
    start[0]     = 1'b1;
    tick();
    load_en[0] = 1'b0;
    start[0]   = 1'b0;
    ma[0][4]   = 8'd200;
    cyc = 0;
    while (done[0] !== 1'b1 && cyc < 1000) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != exp_lat(0)) begin
      n_fail++;
      $display("FAIL load_start latency: got %0d cycles, required %0d", cyc, exp_lat(0));
    end
    run_compute(0, cyc);
    n_checks++;
    if (cyc != exp_lat(0)) begin
      n_fail++;
      $display("FAIL back_to_back latency: got %0d cycles, required %0d", cyc, exp_lat(0));
    end
    read_all(0);
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (got[i] !== exp_c(0, i)) begin
        n_fail++;
        $display("FAIL load_start C[%0d]: got %0d, required %0d", i, got[i], exp_c(0, i));
      end
    end
    $display("back_to_back: latency %0d, C[4]=%0d", cyc, got[4]);
  endtask

  task automatic test_range();
    int bad;
    bad = $urandom_range(9, 15);
    load_elem(0, 1'b1, bad, 8'd77);
    n_checks++;
    if (load_err[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL range_load_err addr %0d: got %b, required 1", bad, load_err[0]);
    end
    load_elem(0, 1'b1, 0, mb[0][0]);
    n_checks++;
    if (load_err[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL good_load_err: got %b, required 0", load_err[0]);
    end
    rd_addr[0] = 4'(bad);
    tick();
    n_checks++;
    if (rd_data[0] !== 8'd0) begin
      n_fail++;
      $display("FAIL range_read addr %0d: got %0d, required 0", bad, rd_data[0]);
    end
    $display("range: out-of-range address %0d handled", bad);
  endtask

  task automatic test_reset_midrun();
    int seen;
    load_bank(0, 1'b0, 0);
    load_bank(0, 1'b1, 0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    n_checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b done=%b, required 0 and 0", busy[0], done[0]);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done[0] === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_done: got %0d done pulses, required 0", seen);
    end
    read_all(0);
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (got[i] !== 8'd0) begin
        n_fail++;
        $display("FAIL abort C[%0d]: got %0d, required 0", i, got[i]);
      end
    end
    $display("reset_midrun: aborted, %0d done pulses", seen);
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      load_en[d]   = 1'b0;
      load_sel[d]  = 1'b0;
      load_addr[d] = 4'd0;
      load_data[d] = 8'd0;
      start[d]     = 1'b0;
      rd_addr[d]   = 4'd0;
    end
    test_reset();
    test_identity();
    test_square();
    test_saturate();
    test_n4();
    test_random();
    test_midrun();
    test_back_to_back();
    test_range();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
